// File: rtl/modport_dut.sv
// modport_dut: dictionary codec mapping 80-bit words to 8-bit indices and back
//   clk              rising-edge system clock
//   reset            synchronous active-high reset, clears outputs and entry count
//   command          00 NOP, 01 COMPRESS, 10 DECOMPRESS, 11 reserved
//   data_in          word to compress
//   compressed_in    code to decompress
//   compressed_out   code produced by the last successful COMPRESS
//   decompressed_out word produced by the last successful DECOMPRESS
//   response         00 idle, 01 compress OK, 10 decompress OK, 11 error
//   index            dictionary entry touched by the last successful operation
//   foundFlag        last COMPRESS hit an existing entry
//   fullFlag         every entry is allocated
module modport_dut #(
    parameter int DATA_W = 80,
    parameter int IDX_W  = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        command,
    input  logic [DATA_W-1:0] data_in,
    input  logic [IDX_W-1:0]  compressed_in,
    output logic [IDX_W-1:0]  compressed_out,
    output logic [DATA_W-1:0] decompressed_out,
    output logic [1:0]        response,
    output logic [IDX_W-1:0]  index,
    output logic              foundFlag,
    output logic              fullFlag
);
    localparam int CW = IDX_W + 1;

    logic [DATA_W-1:0] dict_q [DEPTH];
    logic [CW-1:0]     count_q, count_d;
    logic [IDX_W-1:0]  co_q, co_d, idx_q, idx_d, hit_idx;
    logic [DATA_W-1:0] do_q, do_d;
    logic [1:0]        resp_q, resp_d;
    logic              found_q, found_d, full_q, full_d, hit, we;

    // descending scan so the lowest matching valid index is the one left standing
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (CW'(i) < count_q && dict_q[i] == data_in) begin
                hit = 1'b1;
                hit_idx = IDX_W'(i);
            end
    end

    always_comb begin
        count_d = count_q;
        co_d = co_q;
        do_d = do_q;
        idx_d = idx_q;
        found_d = found_q;
        resp_d = 2'b00;
        we = 1'b0;
        case (command)
            2'b01: begin
                if (hit) begin
                    co_d = hit_idx;
                    idx_d = hit_idx;
                    found_d = 1'b1;
                    resp_d = 2'b01;
                end else if (!count_q[IDX_W]) begin
                    we = 1'b1;
                    co_d = count_q[IDX_W-1:0];
                    idx_d = count_q[IDX_W-1:0];
                    found_d = 1'b0;
                    resp_d = 2'b01;
                    count_d = count_q + 1'b1;
                end else begin
                    found_d = 1'b0;
                    resp_d = 2'b11;
                end
            end
            2'b10: begin
                if ({1'b0, compressed_in} < count_q) begin
                    do_d = dict_q[compressed_in];
                    idx_d = compressed_in;
                    resp_d = 2'b10;
                end else begin
                    resp_d = 2'b11;
                end
            end
            2'b11: resp_d = 2'b11;
            default: ;
        endcase
        full_d = count_d[IDX_W];
    end

    // contents need no reset: validity comes only from count_q
    always_ff @(posedge clk)
        if (!reset && we) dict_q[count_q[IDX_W-1:0]] <= data_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            co_q <= '0;
            do_q <= '0;
            idx_q <= '0;
            resp_q <= '0;
            found_q <= 1'b0;
            full_q <= 1'b0;
        end else begin
            count_q <= count_d;
            co_q <= co_d;
            do_q <= do_d;
            idx_q <= idx_d;
            resp_q <= resp_d;
            found_q <= found_d;
            full_q <= full_d;
        end
    end

    assign compressed_out = co_q;
    assign decompressed_out = do_q;
    assign response = resp_q;
    assign index = idx_q;
    assign foundFlag = found_q;
    assign fullFlag = full_q;
endmodule

// File: tb/tb_modport_dut.sv
// tb_modport_dut: directed and random checks of modport_dut against a queue-based dictionary model
module tb_modport_dut;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  command = 2'b00;
    logic [79:0] data_in = '0;
    logic [7:0]  compressed_in = '0;
    logic [7:0]  compressed_out, index;
    logic [79:0] decompressed_out;
    logic [1:0]  response;
    logic        foundFlag, fullFlag;

    int total = 0;
    int bad = 0;

    logic [79:0] mq[$];
    logic [7:0]  e_co, e_idx;
    logic [79:0] e_do;
    logic [1:0]  e_resp;
    logic        e_found, e_full;

    modport_dut dut (
        .clk(clk), .reset(reset), .command(command), .data_in(data_in),
        .compressed_in(compressed_in), .compressed_out(compressed_out),
        .decompressed_out(decompressed_out), .response(response), .index(index),
        .foundFlag(foundFlag), .fullFlag(fullFlag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // dictionary is a queue: position in the queue is the code
    task automatic model(input logic [1:0] cmd, input logic [79:0] din, input logic [7:0] cin, input bit rst);
        int pos;
        if (rst) begin
            mq.delete();
            e_co = 0; e_idx = 0; e_do = 0; e_resp = 0; e_found = 0;
        end else if (cmd == 2'b01) begin
            pos = -1;
            foreach (mq[i]) if (pos < 0 && mq[i] == din) pos = i;
            if (pos >= 0) begin
                e_co = 8'(pos); e_idx = 8'(pos); e_found = 1; e_resp = 2'b01;
            end else if (mq.size() < 256) begin
                mq.push_back(din);
                e_co = 8'(mq.size() - 1); e_idx = e_co; e_found = 0; e_resp = 2'b01;
            end else begin
                e_found = 0; e_resp = 2'b11;
            end
        end else if (cmd == 2'b10) begin
            if (int'(cin) < mq.size()) begin
                e_do = mq[cin]; e_idx = cin; e_resp = 2'b10;
            end else e_resp = 2'b11;
        end else e_resp = cmd;
        e_full = (mq.size() == 256);
    endtask

    task automatic step(input logic [1:0] cmd, input logic [79:0] din, input logic [7:0] cin, input bit rst);
        command = cmd; data_in = din; compressed_in = cin; reset = rst;
        model(cmd, din, cin, rst);
        @(posedge clk);
        #1;
        chk("co", 80'(compressed_out), 80'(e_co));
        chk("do", decompressed_out, e_do);
        chk("resp", 80'(response), 80'(e_resp));
        chk("idx", 80'(index), 80'(e_idx));
        chk("found", 80'(foundFlag), 80'(e_found));
        chk("full", 80'(fullFlag), 80'(e_full));
    endtask

    initial begin
        step(2'b00, 0, 0, 1);
        chk("rst_resp", 80'(response), 80'(0));
        step(2'b01, 80'h1, 0, 0);
        chk("first_co", 80'(compressed_out), 80'(0));
        step(2'b01, 80'hABCD, 0, 0);
        chk("second_co", 80'(compressed_out), 80'(1));
        step(2'b01, 80'h1, 0, 0);
        chk("hit_found", 80'(foundFlag), 80'(1));
        step(2'b10, 0, 8'd1, 0);
        chk("dec1", decompressed_out, 80'hABCD);
        step(2'b10, 0, 8'd5, 0);
        chk("dec5_resp", 80'(response), 80'(3));
        step(2'b11, 80'h77, 8'd0, 0);
        step(2'b00, 80'h77, 8'd0, 0);
        // reset mid-sequence discards the dictionary
        step(2'b01, 80'h55, 0, 1);
        step(2'b10, 0, 8'd0, 0);
        chk("post_rst_dec", 80'(response), 80'(3));
        step(2'b01, 80'hABCD, 0, 0);
        chk("post_rst_co", 80'(compressed_out), 80'(0));
        // fill to capacity
        step(2'b00, 0, 0, 1);
        for (int v = 0; v < 256; v++) step(2'b01, 80'(v), 0, 0);
        chk("full_set", 80'(fullFlag), 80'(1));
        step(2'b01, 80'h3, 0, 0);
        chk("full_hit", 80'(compressed_out), 80'(3));
        step(2'b01, 80'h1000, 0, 0);
        chk("full_miss", 80'(response), 80'(3));
        step(2'b10, 0, 8'd255, 0);
        chk("dec255", decompressed_out, 80'(255));
        // random traffic over a small value pool to mix hits and misses
        step(2'b00, 0, 0, 1);
        for (int n = 0; n < 600; n++) begin
            logic [79:0] d;
            d = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom, 16'($urandom)} : 80'($urandom_range(0, 47));
            step(2'($urandom_range(0, 3)), d, 8'($urandom_range(0, 63)), $urandom_range(0, 79) == 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
